apb_slave_mem: RTL

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// apb_slave_mem
//   APB completer backed by an internal word-addressed memory. Every transfer
//   is stretched by a fixed number of wait states, then completes with pready
//   for one cycle. Misaligned or out-of-range addresses complete with pslverr
//   and never touch memory.
//
// Ports
//   clk      - single clock, all logic on the rising edge
//   rst      - synchronous active-high reset; also clears the whole memory
//   psel     - completer select
//   penable  - access-phase indicator
//   pwrite   - 1 = write, 0 = read
//   paddr    - byte address (addrWidth bits)
//   pwdata   - write data (dataWidth bits)
//   pstrb    - write byte enables (dataWidth/8 bits), ignored on reads
//   pprot    - protection attributes, accepted and ignored
//   prdata   - read data, zero whenever pready is low
//   pready   - transfer complete, high for exactly one cycle per transfer
//   pslverr  - error response, only meaningful alongside pready
module apb_slave_mem #(
  parameter int addrWidth  = 32,
  parameter int dataWidth  = 32,
  parameter int depth      = 64,
  parameter int waitStates = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [addrWidth-1:0]   paddr,
  input  logic [dataWidth-1:0]   pwdata,
  input  logic [dataWidth/8-1:0] pstrb,
  input  logic [2:0]             pprot,
  output logic [dataWidth-1:0]   prdata,
  output logic                   pready,
  output logic                   pslverr
);

  localparam int strbWidth = dataWidth / 8;
  localparam int lsbBits   = (strbWidth > 1) ? $clog2(strbWidth) : 0;
  localparam int idxBits   = (depth > 1) ? $clog2(depth) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } stateT;

  stateT                 state;
  stateT                 stateNext;
  logic [3:0]            waitCnt;
  logic [3:0]            waitCntNext;
  logic                  capture;

  // Transfer attributes latched in the setup phase.
  logic [addrWidth-1:0]  paddrQ;
  logic                  pwriteQ;
  logic [dataWidth-1:0]  pwdataQ;
  logic [strbWidth-1:0]  pstrbQ;

  logic [addrWidth-1:0]  wordIdx;
  logic [idxBits-1:0]    memIdx;
  logic                  misaligned;
  logic                  outOfRange;
  logic                  addrErr;
  logic                  doneActive;
  logic                  memWrite;

  logic [dataWidth-1:0]  mem [depth];

  // pprot carries no meaning for this memory.
  logic                  unusedBits;
  assign unusedBits = ^pprot;

  // ---------------------------------------------------------------------------
  // Address decode on the latched address
  // ---------------------------------------------------------------------------
  assign wordIdx    = paddrQ >> lsbBits;
  assign memIdx     = wordIdx[idxBits-1:0];
  assign misaligned = (paddrQ & addrWidth'(strbWidth - 1)) != '0;
  assign outOfRange = wordIdx >= addrWidth'(depth);
  assign addrErr    = misaligned || outOfRange;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    if (rst) begin
      state   <= IDLE;
      waitCnt <= '0;
      paddrQ  <= '0;
      pwriteQ <= 1'b0;
      pwdataQ <= '0;
      pstrbQ  <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (capture) begin
        paddrQ  <= paddr;
        pwriteQ <= pwrite;
        pwdataQ <= pwdata;
        pstrbQ  <= pstrb;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    stateNext   = state;
    waitCntNext = waitCnt;
    capture     = 1'b0;
    unique case (state)
      IDLE: begin
        // penable without a preceding setup is not a transfer.
        if (psel && !penable) begin
          capture     = 1'b1;
          waitCntNext = 4'(waitStates);
          stateNext   = (waitStates > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (!psel) begin
          // Requester abandoned the transfer.
          stateNext   = IDLE;
          waitCntNext = '0;
        end else if (penable) begin
          if (waitCnt == 4'd1) begin
            stateNext = DONE;
          end
          waitCntNext = waitCnt - 4'd1;
        end
      end
      DONE: begin
        // Always back to IDLE so a new setup can follow with no gap.
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Completion outputs. Gated by psel (abort in DONE) and rst (a reset edge
  // in progress must never be seen as a completion).
  // ---------------------------------------------------------------------------
  assign doneActive = (state == DONE) && psel && !rst;
  assign memWrite   = doneActive && pwriteQ && !addrErr;

  always_comb begin
    pready  = doneActive;
    pslverr = doneActive && addrErr;
    prdata  = '0;
    if (doneActive && !pwriteQ && !addrErr) begin
      prdata = mem[memIdx];
    end
  end

  // ---------------------------------------------------------------------------
  // Memory: byte-masked write in DONE, full clear under reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the memory is reset word by word because its post-reset
      // contents are visible to software; this keeps it in flops rather than
      // a RAM macro.
      for (int w = 0; w < depth; w++) begin
        mem[w] <= '0;
      end
    end else if (memWrite) begin
      for (int i = 0; i < strbWidth; i++) begin
        if (pstrbQ[i]) begin
          mem[memIdx][8*i +: 8] <= pwdataQ[8*i +: 8];
        end
      end
    end
  end

endmodule
